// File: rtl/s27_pkg.sv
// Shared types and constants for the s27 scan/BIST array: FSM encoding,
// LFSR/MISR feedback masks and per-lane bit offsets.
package s27_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_e;

    // Feedback masks, bit i set for each x^(i+1) term of the polynomial
    localparam logic [15:0] TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1

    localparam int G0 = 0;
    localparam int G1 = 1;
    localparam int G2 = 2;
    localparam int G3 = 3;

    localparam int Q5 = 0;
    localparam int Q6 = 1;
    localparam int Q7 = 2;

    function automatic logic [31:0] tap_mask(input int width);
        return (width == 32) ? TAPS_32 : {16'h0000, TAPS_16};
    endfunction

endpackage

// File: rtl/s27_lane.sv
// Combinational next-state and output logic of one s27 benchmark lane.
module s27_lane
    import s27_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] g,
    output logic [2:0] next,
    output logic       g17
);

    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

    always_comb begin
        g14 = ~g[G0];
        g8  = state[Q6] & g14;
        g12 = ~(state[Q7] | g[G1]);
        g15 = g8 | g12;
        g16 = g8 | g[G3];
        g13 = ~(g12 | g[G2]);
        g9  = ~(g15 & g16);
        g11 = ~(g9 | state[Q5]);
        g10 = ~(g11 | g14);
        g17 = ~g11;

        next       = '0;
        next[Q5]   = g10;
        next[Q6]   = g11;
        next[Q7]   = g13;
    end

endmodule

// File: rtl/s27_scan_array.sv
// Array of s27 lanes sharing one scan chain, with an LFSR/MISR BIST
// controller that exercises all lanes and compacts their outputs.
module s27_scan_array
    import s27_pkg::*;
#(
    parameter int                 LANES     = 4,
    parameter int                 MISR_W    = 16,
    parameter int                 PATTERNS  = 64,
    parameter logic [MISR_W-1:0]  LFSR_SEED = MISR_W'(16'hACE1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 func_en,
    input  logic [4*LANES-1:0]   pi,
    output logic [LANES-1:0]     po,
    input  logic                 scan_en,
    input  logic                 scan_in,
    output logic                 scan_out,
    input  logic                 bist_start,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic [MISR_W-1:0]    bist_sig
);

    localparam int NBITS = 3 * LANES;
    localparam int NPI   = 4 * LANES;
    localparam int CNT_W = $clog2(PATTERNS + 1);

    localparam logic [31:0]       TAPS_ALL = tap_mask(MISR_W);
    localparam logic [MISR_W-1:0] TAPS     = TAPS_ALL[MISR_W-1:0];
    localparam logic [CNT_W-1:0]  LAST_PAT = CNT_W'(PATTERNS - 1);

    bist_state_e        st_q, st_d;
    logic [NBITS-1:0]   state_q, state_d;
    logic [NBITS-1:0]   nxt_state;
    logic [MISR_W-1:0]  lfsr_q, lfsr_d;
    logic [MISR_W-1:0]  misr_q, misr_d;
    logic [MISR_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               busy;
    logic [NPI-1:0]     pi_bist;
    logic [NPI-1:0]     app_pi;
    logic [MISR_W-1:0]  fold;

    assign busy = (st_q == INIT) || (st_q == RUN);

    // The LFSR pattern is replicated across all lanes' primary inputs
    always_comb begin
        pi_bist = '0;
        for (int j = 0; j < NPI; j++) begin
            pi_bist[j] = lfsr_q[j % MISR_W];
        end
    end

    assign app_pi = busy ? pi_bist : pi;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        s27_lane u_lane (
            .state (state_q[3*i +: 3]),
            .g     (app_pi[4*i +: 4]),
            .next  (nxt_state[3*i +: 3]),
            .g17   (po[i])
        );
    end

    always_comb begin
        fold = '0;
        for (int j = 0; j < LANES; j++) begin
            fold[j % MISR_W] = fold[j % MISR_W] ^ po[j];
        end
    end

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;

        case (st_q)
            IDLE: begin
                if (bist_start) st_d = INIT;
            end
            INIT: begin
                state_d = '0;
                lfsr_d  = LFSR_SEED;
                misr_d  = '0;
                cnt_d   = '0;
                st_d    = RUN;
            end
            RUN: begin
                state_d = nxt_state;
                lfsr_d  = {lfsr_q[MISR_W-2:0], ^(lfsr_q & TAPS)};
                misr_d  = {misr_q[MISR_W-2:0], ^(misr_q & TAPS)} ^ fold;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_PAT) st_d = DONE;
            end
            DONE: begin
                sig_d = misr_q;
                st_d  = IDLE;
            end
            default: st_d = IDLE;
        endcase

        // BIST owns the array while busy; otherwise scan beats functional
        if (!busy) begin
            if (scan_en) begin
                state_d = {state_q[NBITS-2:0], scan_in};
            end else if (func_en) begin
                state_d = nxt_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            state_q <= '0;
            lfsr_q  <= '0;
            misr_q  <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign scan_out  = state_q[NBITS-1];
    assign bist_busy = busy;
    assign bist_done = (st_q == DONE);
    assign bist_sig  = sig_q;

endmodule

// File: doc/s27_scan_array.md
Name: s27_scan_array

Overview:
- Parametrised successor of the team's single-instance s27 benchmark core: LANES independent s27 state machines share one clock.
- All 3*LANES state flops are stitched into a single scan chain.
- A built-in self-test (BIST) controller drives LFSR patterns into the array and compacts the outputs into a MISR signature.
- Serves as the synthesisable golden target for the logic-simulator lab flow, covering functional, scan and BIST modes.

Parameters:
- LANES, 4, number of s27 lanes (1..16)
- MISR_W, 16, LFSR/MISR width; only 16 or 32 are supported
- PATTERNS, 64, BIST run length in cycles (>=1)
- LFSR_SEED, 16'hACE1, nonzero LFSR seed, zero-extended when MISR_W=32

Ports:
- clk  in  1  the single clock
- rst_n  in  1  asynchronous, active-low reset
- func_en  in  1  enables functional state update
- pi  in  4*LANES  primary inputs; pi[4i+0..3] = lane i G0..G3
- po  out  LANES  lane i G17, combinational from state and applied inputs
- scan_en  in  1  shift enable
- scan_in  in  1  chain serial input
- scan_out  out  1  last chain flop
- bist_start  in  1  start request, level-sampled in IDLE
- bist_busy  out  1  high while BIST runs
- bist_done  out  1  one-cycle pulse at completion
- bist_sig  out  MISR_W  final signature

Behaviour:
- Lane logic, state (Q5,Q6,Q7), inputs G0..G3:
  - G14=~G0; G8=Q6&G14; G12=~(Q7|G1); G15=G8|G12; G16=G8|G3; G13=~(G12|G2)
  - G9=~(G15&G16); G11=~(G9|Q5); G10=~(G11|G14); G17=~G11
  - Next state: Q5<=G10, Q6<=G11, Q7<=G13
- Reset (async, rst_n=0):
  - All state flops, LFSR, MISR and bist_sig = 0; FSM = IDLE; bist_busy=0; bist_done=0; scan_out=0.
  - Reset mid-BIST aborts the run without a done pulse.
- Update priority per clock: BIST active > scan_en > func_en > hold.
- Scan chain:
  - Bit order lane0 Q5,Q6,Q7, lane1 Q5..., index k = 3*lane + {0,1,2}.
  - Shift: bit0 <= scan_in, bit k+1 <= bit k.
  - scan_out = bit 3*LANES-1, so latency is 3*LANES cycles.
  - scan_en is ignored while bist_busy.
- Applied inputs: pi in IDLE; pi_bist[j] = lfsr[j mod MISR_W] while BIST is active. po reflects the applied inputs.
- BIST FSM:
  - IDLE: bist_start=1 -> INIT.
  - INIT (1 cycle): state flops=0, lfsr=LFSR_SEED, misr=0, bist_busy=1 -> RUN.
  - RUN (exactly PATTERNS cycles):
    - Functional update with pi_bist.
    - LFSR steps Fibonacci left shift.
    - misr <= ((misr<<1) | fb(misr)) ^ fold(po), where fold xors po[j] into bit j mod MISR_W.
    - Taps: MISR_W=16 uses x^16+x^14+x^13+x^11+1; MISR_W=32 uses x^32+x^22+x^2+x+1.
    - After the last pattern -> DONE.
  - DONE (1 cycle): bist_sig <= misr; bist_done=1; bist_busy=0 -> IDLE.
- bist_busy is high for 1+PATTERNS cycles total.
- bist_start while busy or in DONE is ignored. Holding it high restarts on the cycle after DONE.
- Array state after BIST is whatever RUN left. bist_sig holds until the next DONE.

Decomposition:
- Package s27_pkg holds:
  - BIST FSM enum {IDLE, INIT, RUN, DONE}
  - Tap masks for widths 16 and 32
  - Lane bit-offset constants (G0..G3 = 0..3, Q5..Q7 = 0..2)
- Sub-module s27_lane: purely combinational; inputs state[2:0] and g[3:0]; outputs next[2:0] and g17.
- Flops, scan chain and BIST live in the top level.

Test Plan:
- Reset, pi=0, func_en=1 -> state stays 000, po=4'b1111 every cycle.
- Lane0 pi nibble G0..G3=1,0,0,1 (pi=16'h0009) from reset with func_en=1 -> lane0 (Q5,Q6,Q7)=(0,1,0) next cycle, po[0]=0; other lanes stay 000 with po=1.
- scan_en=1, shift 12 bits 1011_0010_1110 (LSB first), then 12 zeros -> same sequence on scan_out starting on cycle 13; func_en toggling during the shift has no effect.
- bist_start pulse (LANES=4, PATTERNS=64) -> bist_busy high for exactly 65 cycles, one-cycle bist_done, bist_sig equals the reference-model signature; a repeat run gives the identical signature.
- bist_start asserted during RUN -> ignored, single done. rst_n low at RUN cycle 20 -> busy=0, sig=0, no done. Next start gives the golden signature.
- scan_en=1 during BIST -> chain unaffected and signature unchanged vs the golden value.
